// File: rtl/mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_counter                                                     |
// | Purpose  : Parametrised modulo-N time-base counter (seconds / minutes /    |
// |            hours stage). All stages run on the one clk_1Hz clock and are   |
// |            chained by wiring carry_out of one stage to en of the next.     |
// |            Supports up/down counting, synchronous clear, parallel load     |
// |            with saturating clamp, and a combinational carry so a cascade   |
// |            rolls over on a single edge (00:59 -> 01:00).                   |
// | Params   : MODULUS (count range 0..MODULUS-1, 2..2**WIDTH)                 |
// |            WIDTH   (width of count / load_val)                             |
// |            INIT    (count value after reset, < MODULUS)                    |
// | Ports    : clk_1Hz   in  1      clock, rising edge                         |
// |            rst       in  1      asynchronous active-high reset             |
// |            en        in  1      count enable                               |
// |            up_dn     in  1      1 = count up, 0 = count down               |
// |            clear     in  1      synchronous clear to 0 (highest priority)  |
// |            load      in  1      synchronous parallel load                  |
// |            load_val  in  WIDTH  value for load (clamped to MODULUS-1)      |
// |            count     out WIDTH  registered count                           |
// |            tick      out 1      registered pulse, cycle after a wrap edge  |
// |            carry_out out 1      combinational: next edge will wrap         |
// | Option   : MOD_COUNTER_BCD_EN adds bcd_tens / bcd_ones (out 4 each),       |
// |            registered decimal digits of count; requires MODULUS <= 100.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mod_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6,
  parameter int INIT    = 0
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             carry_out
`ifdef MOD_COUNTER_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_INIT    = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
  // One extra bit so MODULUS = 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH + 1)'(MODULUS);

  // Elaboration-time legality checks on the parameters.
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if ((INIT < 0) || (INIT >= MODULUS)) begin : g_bad_init
    $error("mod_counter: INIT must be below MODULUS");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_clamped;

  // Wrap is detected by explicit compare with the terminal value rather than
  // arithmetic overflow, so MODULUS = 2**WIDTH still reports tick.
  always_comb begin
    w_at_max       = (count_q == c_MAX);
    w_at_zero      = (count_q == '0);
    w_load_clamped = ({1'b0, load_val} < c_MOD_EXT) ? load_val : c_MAX;

    count_d = count_q;
    tick_d  = 1'b0;

    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = w_load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          count_d = '0;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q + c_ONE;
        end
      end else begin
        if (w_at_zero) begin
          count_d = c_MAX;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q - c_ONE;
        end
      end
    end

    // Must mirror exactly the conditions that set tick_d so a downstream
    // stage enabled by it steps on the same edge this stage wraps.
    carry_out = en & ~clear & ~load & (up_dn ? w_at_max : w_at_zero);
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      count_q <= c_INIT;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;

`ifdef MOD_COUNTER_BCD_EN
  if (MODULUS > 100) begin : g_bcd_range_err
    $error("mod_counter: BCD outputs require MODULUS <= 100");
  end

  localparam logic [3:0] c_BCD_TENS_INIT = 4'(INIT / 10);
  localparam logic [3:0] c_BCD_ONES_INIT = 4'(INIT % 10);

  logic [3:0] bcd_tens_q, bcd_tens_d;
  logic [3:0] bcd_ones_q, bcd_ones_d;
  logic [7:0] w_count_d8;

  // Digits are derived from count_d (not count_q) so they load on the same
  // edge as count and are never a cycle behind. Values are < 100, so 8 bits
  // hold every legal count.
  always_comb begin
    w_count_d8 = 8'(count_d);
    bcd_tens_d = 4'(w_count_d8 / 8'd10);
    bcd_ones_d = 4'(w_count_d8 % 8'd10);
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      bcd_tens_q <= c_BCD_TENS_INIT;
      bcd_ones_q <= c_BCD_ONES_INIT;
    end else begin
      bcd_tens_q <= bcd_tens_d;
      bcd_ones_q <= bcd_ones_d;
    end
  end

  assign bcd_tens = bcd_tens_q;
  assign bcd_ones = bcd_ones_q;
`endif

endmodule
`default_nettype wire
